// File: rtl/lbm_pkg.sv
// Shared types and defaults for the lattice-Boltzmann sweep sequencer.
package lbm_pkg;

  localparam int DEFAULT_GRID_X     = 16;
  localparam int DEFAULT_GRID_Y     = 16;
  localparam int DEFAULT_ITER_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    CELL_ISSUE,
    CELL_WAIT,
    STREAM,
    ITER_END,
    DONE
  } sweep_state_t;

  typedef enum logic [2:0] {
    FLUID,
    LID,
    BOTTOM,
    LEFT,
    RIGHT
  } cell_class_t;

  // A one-cell dimension still needs a one-bit coordinate port.
  function automatic int coordWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lbm_boundary_classifier.sv
// Maps registered cell coordinates to a boundary class; lid wins over walls,
// bottom over the side walls.
module lbm_boundary_classifier
  import lbm_pkg::*;
#(
  parameter int GRID_X = DEFAULT_GRID_X,
  parameter int GRID_Y = DEFAULT_GRID_Y,
  parameter int XW     = coordWidth(GRID_X),
  parameter int YW     = coordWidth(GRID_Y)
) (
  input  logic [XW-1:0] i_cellX,
  input  logic [YW-1:0] i_cellY,
  output cell_class_t   o_cellClass,
  output logic          o_lid,
  output logic          o_bottomWall,
  output logic          o_leftWall,
  output logic          o_rightWall
);

  always_comb begin
    o_cellClass = FLUID;
    if (i_cellY == YW'(GRID_Y - 1))      o_cellClass = LID;
    else if (i_cellY == '0)              o_cellClass = BOTTOM;
    else if (i_cellX == '0)              o_cellClass = LEFT;
    else if (i_cellX == XW'(GRID_X - 1)) o_cellClass = RIGHT;
  end

  assign o_lid        = (o_cellClass == LID);
  assign o_bottomWall = (o_cellClass == BOTTOM);
  assign o_leftWall   = (o_cellClass == LEFT);
  assign o_rightWall  = (o_cellClass == RIGHT);

endmodule

// File: rtl/lbm_sweep_sequencer.sv
// Per-iteration sequencer: collide every cell one at a time, then stream the
// whole lattice, repeating for the requested number of time steps.
module lbm_sweep_sequencer
  import lbm_pkg::*;
#(
  parameter  int GRID_X        = DEFAULT_GRID_X,
  parameter  int GRID_Y        = DEFAULT_GRID_Y,
  parameter  int ADDRESS_WIDTH = $clog2(GRID_X * GRID_Y),
  parameter  int ITER_WIDTH    = DEFAULT_ITER_WIDTH,
  localparam int XW            = coordWidth(GRID_X),
  localparam int YW            = coordWidth(GRID_Y)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     i_run,
  input  logic [ITER_WIDTH-1:0]    i_numIters,
  input  logic                     i_initDone,
  input  logic                     i_cellDone,
  input  logic                     i_abort,
  output logic [ADDRESS_WIDTH-1:0] o_cellAddr,
  output logic [XW-1:0]            o_cellX,
  output logic [YW-1:0]            o_cellY,
  output cell_class_t              o_cellClass,
  output logic                     o_lid,
  output logic                     o_bottomWall,
  output logic                     o_leftWall,
  output logic                     o_rightWall,
  output logic                     o_cellStart,
  output logic                     o_streamWe,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ITER_WIDTH-1:0]    o_iterCount
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(GRID_X * GRID_Y - 1);
  localparam logic [XW-1:0]            LAST_X    = XW'(GRID_X - 1);

  sweep_state_t             r_state;
  sweep_state_t             w_nextState;
  logic [ADDRESS_WIDTH-1:0] r_cellAddr;
  logic [XW-1:0]            r_cellX;
  logic [YW-1:0]            r_cellY;
  logic [ITER_WIDTH-1:0]    r_iterCount;
  logic [ITER_WIDTH-1:0]    r_numIters;
  logic                     w_lastAddr;
  logic                     w_addrClear;
  logic                     w_addrInc;
  logic                     w_iterClear;
  logic                     w_iterInc;
  logic                     w_latchIters;

  assign w_lastAddr = (r_cellAddr == LAST_ADDR);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_addrClear  = 1'b0;
    w_addrInc    = 1'b0;
    w_iterClear  = 1'b0;
    w_iterInc    = 1'b0;
    w_latchIters = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_run) begin
          w_nextState  = WAIT_INIT;
          w_latchIters = 1'b1;
          w_addrClear  = 1'b1;
          w_iterClear  = 1'b1;
        end
      end
      WAIT_INIT: begin
        if (i_initDone) w_nextState = (r_numIters == '0) ? DONE : CELL_ISSUE;
      end
      CELL_ISSUE: w_nextState = CELL_WAIT;
      CELL_WAIT: begin
        if (i_cellDone) begin
          if (w_lastAddr) begin
            w_addrClear = 1'b1;
            w_nextState = STREAM;
          end else begin
            w_addrInc   = 1'b1;
            w_nextState = CELL_ISSUE;
          end
        end
      end
      STREAM: begin
        if (w_lastAddr) begin
          w_addrClear = 1'b1;
          w_nextState = ITER_END;
        end else begin
          w_addrInc = 1'b1;
        end
      end
      ITER_END: begin
        w_iterInc = 1'b1;
        if (r_iterCount + ITER_WIDTH'(1) == r_numIters) begin
          w_nextState = DONE;
        end else begin
          w_addrClear = 1'b1;
          w_nextState = CELL_ISSUE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    // Abort freezes the counters where they are and drops straight to idle.
    if (i_abort && (r_state != IDLE)) begin
      w_nextState = IDLE;
      w_addrClear = 1'b0;
      w_addrInc   = 1'b0;
      w_iterInc   = 1'b0;
    end
  end

  // Coordinates track the address as counters so no divider is needed.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cellAddr  <= '0;
      r_cellX     <= '0;
      r_cellY     <= '0;
      r_iterCount <= '0;
      r_numIters  <= '0;
    end else begin
      if (w_latchIters) r_numIters <= i_numIters;
      if (w_iterClear)    r_iterCount <= '0;
      else if (w_iterInc) r_iterCount <= r_iterCount + ITER_WIDTH'(1);
      if (w_addrClear) begin
        r_cellAddr <= '0;
        r_cellX    <= '0;
        r_cellY    <= '0;
      end else if (w_addrInc) begin
        r_cellAddr <= r_cellAddr + ADDRESS_WIDTH'(1);
        if (r_cellX == LAST_X) begin
          r_cellX <= '0;
          r_cellY <= r_cellY + YW'(1);
        end else begin
          r_cellX <= r_cellX + XW'(1);
        end
      end
    end
  end

  lbm_boundary_classifier #(
    .GRID_X (GRID_X),
    .GRID_Y (GRID_Y),
    .XW     (XW),
    .YW     (YW)
  ) u_classifier (
    .i_cellX      (r_cellX),
    .i_cellY      (r_cellY),
    .o_cellClass  (o_cellClass),
    .o_lid        (o_lid),
    .o_bottomWall (o_bottomWall),
    .o_leftWall   (o_leftWall),
    .o_rightWall  (o_rightWall)
  );

  assign o_cellAddr  = r_cellAddr;
  assign o_cellX     = r_cellX;
  assign o_cellY     = r_cellY;
  assign o_iterCount = r_iterCount;
  assign o_cellStart = (r_state == CELL_ISSUE);
  assign o_streamWe  = (r_state == STREAM);
  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == DONE);

endmodule

// File: tb/tb_lbm_sweep_sequencer.sv
// Self-checking bench for the sweep sequencer on a 4x4 lattice with a
// randomised-latency collide responder and an arithmetic reference model.
module tb_lbm_sweep_sequencer;
  import lbm_pkg::*;

  localparam int GX = 4;
  localparam int GY = 4;
  localparam int N  = GX * GY;
  localparam int AW = 4;
  localparam int IW = 16;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          i_run = 1'b0;
  logic [IW-1:0] i_numIters = '0;
  logic          i_initDone = 1'b1;
  logic          i_abort = 1'b0;
  logic          respDone = 1'b0;
  logic          spurDone = 1'b0;
  logic          i_cellDone;

  logic [AW-1:0] o_cellAddr;
  logic [1:0]    o_cellX;
  logic [1:0]    o_cellY;
  cell_class_t   o_cellClass;
  logic          o_lid, o_bottomWall, o_leftWall, o_rightWall;
  logic          o_cellStart, o_streamWe, o_busy, o_done;
  logic [IW-1:0] o_iterCount;

  assign i_cellDone = respDone | spurDone;

  always #5 Clk = ~Clk;

  lbm_sweep_sequencer #(
    .GRID_X     (GX),
    .GRID_Y     (GY),
    .ITER_WIDTH (IW)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .i_run        (i_run),
    .i_numIters   (i_numIters),
    .i_initDone   (i_initDone),
    .i_cellDone   (i_cellDone),
    .i_abort      (i_abort),
    .o_cellAddr   (o_cellAddr),
    .o_cellX      (o_cellX),
    .o_cellY      (o_cellY),
    .o_cellClass  (o_cellClass),
    .o_lid        (o_lid),
    .o_bottomWall (o_bottomWall),
    .o_leftWall   (o_leftWall),
    .o_rightWall  (o_rightWall),
    .o_cellStart  (o_cellStart),
    .o_streamWe   (o_streamWe),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_iterCount  (o_iterCount)
  );

  int checks = 0;
  int passes = 0;
  int respLat = 3;
  int respCnt = 0;
  int startQ[$];
  int streamQ[$];
  int doneCnt = 0;

  // Collide pipeline stand-in: answers each cell_start respLat cycles later.
  always @(negedge Clk) begin
    if (o_cellStart)       respCnt <= respLat;
    else if (respCnt != 0) respCnt <= respCnt - 1;
    respDone <= (respCnt == 1);
  end

  // Event recorder; tasks snapshot sizes and compare against the model.
  always @(negedge Clk) begin
    if (o_cellStart) startQ.push_back(int'(o_cellAddr));
    if (o_streamWe)  streamQ.push_back(int'(o_cellAddr));
    if (o_done)      doneCnt <= doneCnt + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic startRun(input int iters);
    i_numIters = IW'(iters);
    i_run = 1'b1;
    tick();
    i_run = 1'b0;
  endtask

  function automatic int budgetFor(input int iters, input int lat);
    return iters * (N * (lat + 3) + N + 4) + 20;
  endfunction

  task automatic waitDone(input int budget, output bit ok);
    int d0 = doneCnt;
    int c = 0;
    while (doneCnt == d0 && c < budget) begin
      tick();
      c++;
    end
    ok = (doneCnt != d0);
  endtask

  // Model: the k-th collide launch and k-th stream write both target k mod N.
  function automatic int badStarts(input int from, input int cnt);
    int bad = 0;
    for (int i = 0; i < cnt; i++)
      if (from + i >= startQ.size() || startQ[from + i] != (i % N)) bad++;
    return bad;
  endfunction

  function automatic int badStreams(input int from, input int cnt);
    int bad = 0;
    for (int i = 0; i < cnt; i++)
      if (from + i >= streamQ.size() || streamQ[from + i] != (i % N)) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    checks++;
    if ({o_busy, o_cellStart, o_streamWe, o_done} !== 4'b0)
      $display("[TB] FAIL reset_ctrl: got %b want 0000", {o_busy, o_cellStart, o_streamWe, o_done});
    else passes++;
    checks++;
    if ({o_cellAddr, o_cellX, o_cellY} !== 8'h00)
      $display("[TB] FAIL reset_addr: got %h want 00", {o_cellAddr, o_cellX, o_cellY});
    else passes++;
    checks++;
    if (o_iterCount !== 16'd0) $display("[TB] FAIL reset_iter: got %0d want 0", o_iterCount);
    else passes++;
    checks++;
    if ({o_lid, o_bottomWall, o_leftWall, o_rightWall} !== 4'b0100)
      $display("[TB] FAIL reset_flags: got %b want 0100", {o_lid, o_bottomWall, o_leftWall, o_rightWall});
    else passes++;
    @(posedge Clk);
    #1 Reset = 1'b1;
    tick();
  endtask

  task automatic test_single_iter();
    int s0 = startQ.size();
    int w0 = streamQ.size();
    int d0 = doneCnt;
    bit ok;
    respLat = 3;
    startRun(1);
    waitDone(budgetFor(1, 3), ok);
    tick();
    checks++;
    if (!ok) $display("[TB] FAIL single_done_seen: got 0 want 1"); else passes++;
    checks++;
    if (startQ.size() - s0 != N) $display("[TB] FAIL single_starts: got %0d want %0d", startQ.size() - s0, N);
    else passes++;
    checks++;
    if (badStarts(s0, N) != 0) $display("[TB] FAIL single_start_addrs: got %0d bad want 0", badStarts(s0, N));
    else passes++;
    checks++;
    if (streamQ.size() - w0 != N) $display("[TB] FAIL single_streams: got %0d want %0d", streamQ.size() - w0, N);
    else passes++;
    checks++;
    if (badStreams(w0, N) != 0) $display("[TB] FAIL single_stream_addrs: got %0d bad want 0", badStreams(w0, N));
    else passes++;
    checks++;
    if (doneCnt - d0 != 1) $display("[TB] FAIL single_done_pulses: got %0d want 1", doneCnt - d0);
    else passes++;
    checks++;
    if (o_iterCount !== 16'd1 || o_busy !== 1'b0)
      $display("[TB] FAIL single_final: got iter=%0d busy=%b want iter=1 busy=0", o_iterCount, o_busy);
    else passes++;
  endtask

  task automatic test_classification();
    int badFlags = 0, badCoord = 0, badClass = 0, seenCnt = 0;
    bit seen[N];
    int c = 0;
    respLat = 1;
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
    startRun(1);
    while (c < budgetFor(1, 1)) begin
      int a, x, y;
      bit eL, eB, eLf, eR;
      cell_class_t eC;
      @(negedge Clk);
      if (!o_busy) break;
      a = int'(o_cellAddr);
      x = a % GX;
      y = a / GX;
      eL  = (y == GY - 1);
      eB  = !eL && (y == 0);
      eLf = !eL && !eB && (x == 0);
      eR  = !eL && !eB && !eLf && (x == GX - 1);
      eC  = eL ? LID : eB ? BOTTOM : eLf ? LEFT : eR ? RIGHT : FLUID;
      if ({o_lid, o_bottomWall, o_leftWall, o_rightWall} !== {eL, eB, eLf, eR}) badFlags++;
      if (int'(o_cellX) != x || int'(o_cellY) != y) badCoord++;
      if (o_cellClass !== eC) badClass++;
      if (o_streamWe) seen[a] = 1'b1;
      c++;
    end
    tick();
    for (int i = 0; i < N; i++) if (seen[i]) seenCnt++;
    checks++;
    if (badFlags != 0) $display("[TB] FAIL class_flags: got %0d bad cycles want 0", badFlags); else passes++;
    checks++;
    if (badCoord != 0) $display("[TB] FAIL class_coords: got %0d bad cycles want 0", badCoord); else passes++;
    checks++;
    if (badClass != 0) $display("[TB] FAIL class_enum: got %0d bad cycles want 0", badClass); else passes++;
    checks++;
    if (seenCnt != N) $display("[TB] FAIL class_coverage: got %0d cells want %0d", seenCnt, N); else passes++;
  endtask

  task automatic test_zero_iters();
    int s0 = startQ.size();
    i_numIters = '0;
    i_run = 1'b1;
    tick();
    i_run = 1'b0;
    checks++;
    if ({o_busy, o_done} !== 2'b10 || o_iterCount !== 16'd0)
      $display("[TB] FAIL zero_cycle2: got busy/done=%b iter=%0d want 10 iter=0", {o_busy, o_done}, o_iterCount);
    else passes++;
    tick();
    checks++;
    if (o_done !== 1'b1) $display("[TB] FAIL zero_done_cycle3: got %b want 1", o_done); else passes++;
    tick();
    checks++;
    if ({o_busy, o_done} !== 2'b00) $display("[TB] FAIL zero_after: got %b want 00", {o_busy, o_done});
    else passes++;
    checks++;
    if (startQ.size() != s0 || o_iterCount !== 16'd0)
      $display("[TB] FAIL zero_no_work: got starts=%0d iter=%0d want 0 0", startQ.size() - s0, o_iterCount);
    else passes++;
  endtask

  task automatic test_spurious();
    int s0 = startQ.size();
    int w0 = streamQ.size();
    int d0 = doneCnt;
    int budget;
    bit ok = 1'b0;
    bit finished = 1'b0;
    respLat = int'($urandom_range(2, 4));
    budget = budgetFor(1, respLat);
    fork
      begin
        startRun(1);
        waitDone(budget, ok);
        finished = 1'b1;
      end
      begin
        int c = 0;
        while (!finished && c < budget + 10) begin
          @(negedge Clk);
          if ((o_cellStart || o_streamWe) && ($urandom_range(0, 1) != 0 || o_cellAddr == '0))
            spurDone = 1'b1;
          else
            spurDone = 1'b0;
          c++;
        end
        spurDone = 1'b0;
      end
    join
    tick();
    checks++;
    if (!ok) $display("[TB] FAIL spur_done_seen: got 0 want 1"); else passes++;
    checks++;
    if (startQ.size() - s0 != N || badStarts(s0, N) != 0)
      $display("[TB] FAIL spur_starts: got %0d starts %0d bad want %0d 0", startQ.size() - s0, badStarts(s0, N), N);
    else passes++;
    checks++;
    if (streamQ.size() - w0 != N || badStreams(w0, N) != 0)
      $display("[TB] FAIL spur_streams: got %0d writes %0d bad want %0d 0", streamQ.size() - w0, badStreams(w0, N), N);
    else passes++;
    checks++;
    if (doneCnt - d0 != 1) $display("[TB] FAIL spur_done_pulses: got %0d want 1", doneCnt - d0); else passes++;
  endtask

  task automatic test_abort();
    int d0 = doneCnt;
    int c = 0;
    bit ok;
    respLat = int'($urandom_range(2, 4));
    startRun(3);
    while (o_iterCount != 16'd1 && c < budgetFor(3, respLat)) begin tick(); c++; end
    c = 0;
    while (!o_cellStart && c < 20) begin tick(); c++; end
    tick();
    checks++;
    if (o_iterCount !== 16'd1 || o_busy !== 1'b1 || o_cellStart !== 1'b0)
      $display("[TB] FAIL abort_reach_wait: got iter=%0d busy=%b start=%b want 1 1 0", o_iterCount, o_busy, o_cellStart);
    else passes++;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    checks++;
    if ({o_busy, o_cellStart, o_streamWe, o_done} !== 4'b0)
      $display("[TB] FAIL abort_idle: got %b want 0000", {o_busy, o_cellStart, o_streamWe, o_done});
    else passes++;
    repeat (6) tick();
    checks++;
    if (doneCnt != d0 || o_iterCount !== 16'd1)
      $display("[TB] FAIL abort_hold: got done=%0d iter=%0d want 0 1", doneCnt - d0, o_iterCount);
    else passes++;
    respLat = 2;
    startRun(1);
    checks++;
    if (o_iterCount !== 16'd0 || o_busy !== 1'b1)
      $display("[TB] FAIL abort_restart_clear: got iter=%0d busy=%b want 0 1", o_iterCount, o_busy);
    else passes++;
    waitDone(budgetFor(1, 2), ok);
    tick();
    checks++;
    if (!ok || o_iterCount !== 16'd1 || doneCnt - d0 != 1)
      $display("[TB] FAIL abort_restart_done: got ok=%b iter=%0d done=%0d want 1 1 1", ok, o_iterCount, doneCnt - d0);
    else passes++;
  endtask

  task automatic test_reset_stream();
    int d0 = doneCnt;
    int c = 0;
    respLat = 1;
    startRun(2);
    while (!(o_streamWe && o_iterCount == 16'd1) && c < budgetFor(2, 1)) begin tick(); c++; end
    repeat (3) tick();
    checks++;
    if (o_streamWe !== 1'b1 || o_iterCount !== 16'd1)
      $display("[TB] FAIL rst_reach_stream: got we=%b iter=%0d want 1 1", o_streamWe, o_iterCount);
    else passes++;
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_cellStart, o_streamWe, o_done} !== 4'b0 || {o_cellAddr, o_cellX, o_cellY} !== 8'h00 || o_iterCount !== 16'd0)
      $display("[TB] FAIL rst_immediate: got ctrl=%b addr=%h iter=%0d want 0000 00 0",
               {o_busy, o_cellStart, o_streamWe, o_done}, {o_cellAddr, o_cellX, o_cellY}, o_iterCount);
    else passes++;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (5) tick();
    checks++;
    if (doneCnt != d0 || o_busy !== 1'b0)
      $display("[TB] FAIL rst_no_done: got done=%0d busy=%b want 0 0", doneCnt - d0, o_busy);
    else passes++;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      int iters = int'($urandom_range(1, 3));
      int s0 = startQ.size();
      int w0 = streamQ.size();
      int d0 = doneCnt;
      bit ok;
      respLat = int'($urandom_range(1, 4));
      if (r == 1) i_initDone = 1'b0;
      startRun(iters);
      if (r == 1) begin
        repeat (int'($urandom_range(3, 8))) tick();
        checks++;
        if (o_busy !== 1'b1 || startQ.size() != s0)
          $display("[TB] FAIL b2b_init_hold: got busy=%b starts=%0d want 1 0", o_busy, startQ.size() - s0);
        else passes++;
        i_initDone = 1'b1;
      end
      waitDone(budgetFor(iters, respLat), ok);
      tick();
      checks++;
      if (!ok || doneCnt - d0 != 1)
        $display("[TB] FAIL b2b_done run%0d: got ok=%b pulses=%0d want 1 1", r, ok, doneCnt - d0);
      else passes++;
      checks++;
      if (startQ.size() - s0 != iters * N || badStarts(s0, iters * N) != 0)
        $display("[TB] FAIL b2b_starts run%0d: got %0d starts %0d bad want %0d 0",
                 r, startQ.size() - s0, badStarts(s0, iters * N), iters * N);
      else passes++;
      checks++;
      if (streamQ.size() - w0 != iters * N || badStreams(w0, iters * N) != 0)
        $display("[TB] FAIL b2b_streams run%0d: got %0d writes %0d bad want %0d 0",
                 r, streamQ.size() - w0, badStreams(w0, iters * N), iters * N);
      else passes++;
      checks++;
      if (o_iterCount !== IW'(iters))
        $display("[TB] FAIL b2b_iter run%0d: got %0d want %0d", r, o_iterCount, iters);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single_iter();
    test_classification();
    test_zero_iters();
    test_spurious();
    test_abort();
    test_reset_stream();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
